// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller: PC sequencing, single-outstanding imem request, output holding register
module fetch_ctrl #(
   parameter int               WIDTH    = 5,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             stall,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic             instr_valid,
   output logic [31:0]      instr,
   output logic [WIDTH-1:0] instr_pc,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FETCH    = 2'd1,
      S_WAIT_OUT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
   logic             instr_valid_q, instr_valid_d;

   // State register; reset wins over any coincident ack or redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // Next-state and PC sequencing: redirect beats ack, stall holds the held word
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      case (state_q)
         S_IDLE: begin
            if (br_valid) begin
               pc_d = br_target;
            end
            if (run) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            // A redirect drops any word returning this cycle; the request
            // stays up and simply moves to the new address.
            if (br_valid) begin
               pc_d = br_target;
            end else if (imem_ack) begin
               instr_d       = imem_rdata;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + WIDTH'(1);
               state_d       = S_WAIT_OUT;
            end
         end
         S_WAIT_OUT: begin
            if (br_valid || !stall) begin
               instr_valid_d = 1'b0;
               state_d       = run ? S_FETCH : S_IDLE;
               if (br_valid) begin
                  pc_d = br_target;
               end
            end
         end
         default: begin
            state_d       = S_IDLE;
            instr_valid_d = 1'b0;
         end
      endcase
   end

   // Outputs come straight from registers
   always_comb begin
      imem_req    = (state_q == S_FETCH);
      imem_addr   = pc_q;
      instr_valid = instr_valid_q;
      instr       = instr_q;
      instr_pc    = instr_pc_q;
      busy        = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

   localparam int               WIDTH    = 5;
   localparam int               DEPTH    = 1 << WIDTH;
   localparam logic [WIDTH-1:0] RESET_PC = '0;

   logic             clk;
   logic             rst;
   logic             run;
   logic             br_valid;
   logic [WIDTH-1:0] br_target;
   logic             stall;
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_ack;
   logic [31:0]      imem_rdata;
   logic             instr_valid;
   logic [31:0]      instr;
   logic [WIDTH-1:0] instr_pc;
   logic             busy;

   fetch_ctrl #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr_valid(instr_valid),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [31:0]      word;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        cur;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem [DEPTH];

   // Reference model: next fetch address, whether a request is outstanding,
   // whether a fetched word is being held for decode.
   int m_pc;
   bit m_fetching;
   bit m_holding;
   bit prev_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, compare after the edge
   task automatic cycle(input bit r, input bit rn, input bit br, input int tgt,
                        input bit st, input bit ack);
      exp_t e;
      rst        = r;
      run        = rn;
      br_valid   = br;
      br_target  = tgt[WIDTH-1:0];
      stall      = st;
      imem_ack   = ack;
      imem_rdata = ack ? mem[m_pc] : $urandom;
      if (r) begin
         m_pc       = int'(RESET_PC);
         m_fetching = 1'b0;
         m_holding  = 1'b0;
         sb_q.delete();
      end else if (m_fetching) begin
         if (br) begin
            m_pc = tgt % DEPTH;
         end else if (ack) begin
            e.pc   = m_pc[WIDTH-1:0];
            e.word = mem[m_pc];
            sb_q.push_back(e);
            m_pc       = (m_pc + 1) % DEPTH;
            m_fetching = 1'b0;
            m_holding  = 1'b1;
         end
      end else if (m_holding) begin
         if (br || !st) begin
            m_holding  = 1'b0;
            m_fetching = rn;
            if (br) m_pc = tgt % DEPTH;
         end
      end else begin
         if (br) m_pc = tgt % DEPTH;
         if (rn) m_fetching = 1'b1;
      end
      @(negedge clk);
      #1;
      chk("imem_req", 32'(imem_req), 32'(m_fetching));
      chk("imem_addr", 32'(imem_addr), m_pc);
      chk("busy", 32'(busy), 32'(m_fetching | m_holding));
      chk("instr_valid", 32'(instr_valid), 32'(m_holding));
   endtask

   // Monitor: every newly presented instruction pops the scoreboard; a held one must stay stable
   always @(negedge clk) begin
      if (instr_valid === 1'b1) begin
         if (!prev_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard: unexpected instr 0x%0h pc %0d, none expected at %0t",
                        instr, instr_pc, $time);
            end else begin
               cur = sb_q.pop_front();
               chk("instr_pc", 32'(instr_pc), 32'(cur.pc));
               chk("instr", instr, cur.word);
            end
         end else begin
            chk("instr_pc_hold", 32'(instr_pc), 32'(cur.pc));
            chk("instr_hold", instr, cur.word);
         end
      end
      prev_valid = (instr_valid === 1'b1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + 32'(i);
      m_pc       = int'(RESET_PC);
      m_fetching = 1'b0;
      m_holding  = 1'b0;

      // reset defaults
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      chk("reset_instr", instr, 32'h0);
      chk("reset_instr_pc", 32'(instr_pc), 32'h0);

      // straight-line zero-wait fetch
      for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0, 1);

      // stall while an instruction is held
      for (int i = 0; i < 4 && !m_holding; i++) cycle(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0);

      // redirect coinciding with ack
      for (int i = 0; i < 4 && !m_fetching; i++) cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 1, 1, 20, 0, 1);
      cycle(0, 1, 0, 0, 0, 1);

      // redirect while held and stalled squashes the word
      cycle(0, 1, 1, 5, 1, 0);

      // wrap of the PC past 2^WIDTH-1
      cycle(0, 1, 1, 30, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0, 1);

      // wait states, then drop run during the outstanding fetch
      for (int i = 0; i < 4 && !m_fetching; i++) cycle(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);

      // reset mid-fetch with a coincident ack
      cycle(0, 1, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 1);
      chk("rst_fetch_instr", instr, 32'h0);

      // randomized traffic
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 10) == 0,
               int'($urandom % DEPTH), ($urandom % 3) == 0, ($urandom % 2) == 0);
      end

      // drain and confirm nothing was left unpresented
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
